// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One multiplier bit (LSB first) or one quotient bit (MSB first) is produced
// per cycle; a final FIX cycle applies sign correction and writes HI/LO.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [2:0]       MDOp,
  input  logic [WIDTH-1:0] DataIn1,
  input  logic [WIDTH-1:0] DataIn2,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_next;

  // Datapath registers and their next values
  logic [CW-1:0]      count, count_next;
  logic [2*WIDTH-1:0] acc, acc_next;        // product, or {unused, quotient shift reg}
  logic [WIDTH-1:0]   rem, rem_next;        // divide partial remainder
  logic [WIDTH-1:0]   b, b_next;            // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   dividend, dividend_next;
  logic               is_div, is_div_next;
  logic               neg_res, neg_res_next;
  logic               neg_rem, neg_rem_next;
  logic               div_zero, div_zero_next;
  logic               busy, busy_next;
  logic               done, done_next;
  logic [WIDTH-1:0]   hi, hi_next;
  logic [WIDTH-1:0]   lo, lo_next;

  // Operation decode
  logic op_mul, op_div, op_signed;
  assign op_mul    = (MDOp == 3'b001) || (MDOp == 3'b010);
  assign op_div    = (MDOp == 3'b011) || (MDOp == 3'b100);
  assign op_signed = (MDOp == 3'b001) || (MDOp == 3'b011);

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned
  logic             a_neg, d_neg;
  logic [WIDTH-1:0] a_mag, d_mag;
  assign a_neg = op_signed & DataIn1[WIDTH-1];
  assign d_neg = op_signed & DataIn2[WIDTH-1];
  assign a_mag = a_neg ? (~DataIn1 + 1'b1) : DataIn1;
  assign d_mag = d_neg ? (~DataIn2 + 1'b1) : DataIn2;

  // Shift-add step: conditionally add multiplicand to the high half, shift right
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b} : {(WIDTH+1){1'b0}});

  // Restoring divide step on a WIDTH+1-bit trial remainder
  logic [WIDTH:0] trial, diff;
  logic           trial_ge;
  assign trial    = {rem, acc[WIDTH-1]};
  assign diff     = trial - {1'b0, b};
  assign trial_ge = (trial >= {1'b0, b});

  // The top difference bit is always zero when the subtraction is kept
  logic unused_diff_msb;
  assign unused_diff_msb = diff[WIDTH];

  // Sign-corrected results for the FIX cycle
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_res ? (~acc + 1'b1) : acc;
  assign quo_fix  = neg_res ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
  assign rem_fix  = neg_rem ? (~rem + 1'b1) : rem;

  // Next-state and datapath updates
  always_comb begin
    state_next    = state;
    count_next    = count;
    acc_next      = acc;
    rem_next      = rem;
    b_next        = b;
    dividend_next = dividend;
    is_div_next   = is_div;
    neg_res_next  = neg_res;
    neg_rem_next  = neg_rem;
    div_zero_next = div_zero;
    busy_next     = busy;
    done_next     = 1'b0;
    hi_next       = hi;
    lo_next       = lo;

    case (state)
      IDLE: begin
        if (Start) begin
          if (op_mul || op_div) begin
            is_div_next   = op_div;
            neg_res_next  = a_neg ^ d_neg;
            neg_rem_next  = a_neg;
            div_zero_next = op_div && (DataIn2 == '0);
            dividend_next = DataIn1;
            count_next    = CW'(WIDTH - 1);
            rem_next      = '0;
            busy_next     = 1'b1;
            state_next    = CALC;
            if (op_div) begin
              acc_next = {{WIDTH{1'b0}}, a_mag};
              b_next   = d_mag;
            end else begin
              acc_next = {{WIDTH{1'b0}}, d_mag};
              b_next   = a_mag;
            end
          end else if (MDOp == 3'b101) begin
            hi_next = DataIn1;
          end else if (MDOp == 3'b110) begin
            lo_next = DataIn1;
          end
        end
      end

      CALC: begin
        if (is_div) begin
          rem_next = trial_ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
          acc_next = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], trial_ge};
        end else begin
          acc_next = {mul_sum, acc[WIDTH-1:1]};
        end
        if (count == '0) begin
          state_next = FIX;
        end else begin
          count_next = count - 1'b1;
        end
      end

      FIX: begin
        if (is_div) begin
          if (div_zero) begin
            lo_next = '1;
            hi_next = dividend;
          end else begin
            lo_next = quo_fix;
            hi_next = rem_fix;
          end
        end else begin
          hi_next = prod_fix[2*WIDTH-1:WIDTH];
          lo_next = prod_fix[WIDTH-1:0];
        end
        busy_next  = 1'b0;
        done_next  = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count    <= '0;
      acc      <= '0;
      rem      <= '0;
      b        <= '0;
      dividend <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      count    <= count_next;
      acc      <= acc_next;
      rem      <= rem_next;
      b        <= b_next;
      dividend <= dividend_next;
      is_div   <= is_div_next;
      neg_res  <= neg_res_next;
      neg_rem  <= neg_rem_next;
      div_zero <= div_zero_next;
      busy     <= busy_next;
      done     <= done_next;
      hi       <= hi_next;
      lo       <= lo_next;
    end
  end

  assign Busy = busy;
  assign Done = done;
  assign HI   = hi;
  assign LO   = lo;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers, attached beside the ALU of the MIPS R2000 datapath to add MULT, MULTU, DIV, DIVU, MTHI and MTLO. The datapath issues an operation from the decoded instruction with the two GPR read values. The unit computes one bit per cycle and raises Busy so the controller stalls MFHI/MFLO and further issues. HI and LO are readable combinationally at all times.

## Interface
- WIDTH, 32, operand and HI/LO width; must be >= 2.
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- Start  input  1  issue strobe; sampled only while Busy=0.
- MDOp  input  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 none.
- DataIn1  input  WIDTH  rs value: multiplicand, dividend, or MTHI/MTLO source.
- DataIn2  input  WIDTH  rt value: multiplier or divisor.
- Busy  output  1  operation in progress; HI/LO are stale.
- Done  output  1  one-cycle pulse when HI/LO have just been updated by MULT/DIV.
- HI  output  WIDTH  product high half, or remainder.
- LO  output  WIDTH  product low half, or quotient.

## Operation
- **States:**
  - IDLE: default state.
  - CALC: WIDTH iterations.
  - FIX: sign correction and HI/LO write.
- **IDLE:**
  - Start=1 with a MULT/MULTU/DIV/DIVU op: latch the operand magnitudes. Signed ops use two's-complement absolute value, computed as unsigned WIDTH-bit, so the most negative value becomes 2^(WIDTH-1). Latch the result signs. Load the iteration counter with WIDTH-1. Go to CALC.
  - Start=1 with MTHI/MTLO: write DataIn1 to HI/LO at that edge. Stay in IDLE. Busy and Done remain 0.
  - Start=1 with a none op: no effect.
- **CALC, multiply:** shift-add on a 2·WIDTH accumulator, one multiplier bit per cycle, LSB first.
- **CALC, divide:** restoring division, one quotient bit per cycle, MSB first, with a WIDTH+1-bit partial remainder.
- **CALC exit:** when counter = 0, go to FIX.
- **FIX:**
  - MULT: negate the 2·WIDTH product if the operand signs differ.
  - DIV: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
  - Load HI/LO. Go to IDLE.
- **Divide by zero (both signed and unsigned):** LO = all ones, HI = original DataIn1. No sign fixup.
- **Signed overflow (most-negative ÷ −1):** LO = most-negative value, HI = 0. This is the natural wrap result.
- **Start while Busy=1:** ignored entirely, including MTHI/MTLO. The controller must hold the instruction.
- **HI/LO between updates:** hold their previous values throughout CALC.

## Timing
- Reset values: state IDLE, Busy=0, Done=0, HI=0, LO=0, counter=0, accumulators=0.
- Start accepted at edge E0. Busy=1 from E0 until E(WIDTH+1): WIDTH CALC cycles plus 1 FIX cycle.
- HI/LO update at edge E(WIDTH+1). In that same cycle, Busy falls to 0 and Done=1 for exactly one cycle.
- Latency: WIDTH+1 cycles from the issue edge to valid HI/LO. This is 33 for WIDTH=32.
- A new Start is accepted in the cycle Done=1 (back-to-back issue). If that Start is a MULT/DIV, Busy reasserts at the next edge and Done drops.
- MTHI/MTLO have 1-cycle latency: the value is visible after the issuing edge.
- Busy and Done are registered outputs. HI and LO are direct register outputs.
- RST asserted mid-operation: immediate return to IDLE, all outputs cleared, and the operation is discarded with no Done.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> after 33 cycles Done=1, HI=0xFFFFFFFE, LO=0x00000001; Busy=1 for exactly 33 cycles.
- MULT −3 × 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. Back-to-back issue of MULT 0x80000000 × 0x80000000 on the Done cycle -> HI=0x40000000, LO=0.
- DIV −7 ÷ 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7 ÷ 2 -> LO=3, HI=1.
- DIVU 7 ÷ 0 -> LO=0xFFFFFFFF, HI=7. DIV 0x80000000 ÷ 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0x12345678 while idle -> HI=0x12345678 next cycle, Busy stays 0. MTLO issued while Busy -> LO unchanged, and the final result matches the original operation.
- RST pulsed 10 cycles into a DIV -> HI=LO=0, Busy=0, no Done pulse. A subsequent MULTU 6 × 7 -> LO=42, HI=0.
